// File: rtl/lcd_reader_pkg.sv
// Package: lcd_reader_pkg
// Shared timing defaults, state encoding and helpers for the HD44780-style
// LCD read controller. The write controller imports the same definitions,
// so bus timing and state numbering stay identical on both sides.
`timescale 1ns/1ps
package lcd_reader_pkg;

  // Default bus timing in clk cycles at 50 MHz.
  localparam int DEF_T_AS      = 3;   // RS/RW setup before E rises (>40ns)
  localparam int DEF_T_PW      = 12;  // E high width (>230ns)
  localparam int DEF_T_H       = 1;   // RS/RW hold after E falls (>10ns)
  localparam int DEF_T_GAP     = 13;  // E low between polled reads
  localparam int DEF_MAX_POLLS = 255; // status reads before poll timeout

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } lcd_state_t;

  // Largest of the four waits; sizes the shared cycle timer.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Module: lcd_cycle_timer
// Loadable down-counter with a zero flag. Loading N-1 on entry to a state
// makes zero rise in the N-th cycle spent in that state.
// Ports:
//   clk      in  clock
//   reset    in  asynchronous, active-high; clears the count
//   load     in  load load_val this cycle (takes priority over counting)
//   load_val in  W-bit value to load
//   zero     out count == 0
`timescale 1ns/1ps
module lcd_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/lcd_reader.sv
// Module: lcd_reader
// Read-side controller for an HD44780-style 8-bit LCD bus. Runs RW=1 bus
// cycles, samples the data bus in the last E-high cycle and returns the byte.
// RS=1 reads data RAM; RS=0 reads busy flag + address counter, optionally
// repeating the status read until BF=0 or MAX_POLLS reads have been made.
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   start, CS        read request, accepted in IDLE only when CS=1
//   RS, poll         register select; poll repeats status reads (RS=0 only)
//   rd_data          last sampled byte
//   busy_flag        bit 7 of last status read (0 after a data read)
//   done, timeout    end-of-transaction pulse; timeout valid with done
//   LCD_RS/RW/E      LCD control pins
//   LCD_data_in      data bus from the pad
//   bus_rd           copy of LCD_RW for the pad mux direction control
`timescale 1ns/1ps
module lcd_reader
  import lcd_reader_pkg::*;
#(
  parameter int T_AS      = DEF_T_AS,
  parameter int T_PW      = DEF_T_PW,
  parameter int T_H       = DEF_T_H,
  parameter int T_GAP     = DEF_T_GAP,
  parameter int MAX_POLLS = DEF_MAX_POLLS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       CS,
  input  logic       RS,
  input  logic       poll,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic       done,
  output logic       timeout,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  input  logic [7:0] LCD_data_in,
  output logic       bus_rd
);

  localparam int CW = $clog2(max4(T_AS, T_PW, T_H, T_GAP) + 1);
  localparam logic [7:0] POLL_LAST = 8'(MAX_POLLS - 1);

  lcd_state_t    state;
  logic          poll_mode;
  logic [7:0]    polls;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_zero;

  lcd_cycle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // The timer is reloaded on every state change with the length of the state
  // being entered. HOLD always loads T_GAP: if HOLD goes to DONE instead, the
  // value is simply unused, so the load does not depend on the poll decision.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        tmr_load = start & CS;
        tmr_val  = CW'(T_AS - 1);
      end
      ST_SETUP: begin
        tmr_load = tmr_zero;
        tmr_val  = CW'(T_PW - 1);
      end
      ST_PULSE: begin
        tmr_load = tmr_zero;
        tmr_val  = CW'(T_H - 1);
      end
      ST_HOLD: begin
        tmr_load = tmr_zero;
        tmr_val  = CW'(T_GAP - 1);
      end
      ST_GAP: begin
        tmr_load = tmr_zero;
        tmr_val  = CW'(T_AS - 1);
      end
      default: begin
        tmr_load = 1'b0;
        tmr_val  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      poll_mode <= 1'b0;
      polls     <= 8'd0;
      rd_data   <= 8'd0;
      busy_flag <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_RW    <= 1'b0;
      LCD_E     <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && CS) begin
            LCD_RS    <= RS;
            poll_mode <= poll & ~RS;
            polls     <= 8'd0;
            LCD_RW    <= 1'b1;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_zero) begin
            LCD_E <= 1'b1;
            state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          // Last E-high cycle: the LCD output is settled, capture it.
          if (tmr_zero) begin
            LCD_E     <= 1'b0;
            rd_data   <= LCD_data_in;
            busy_flag <= LCD_data_in[7] & ~LCD_RS;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
            // polls stops at MAX_POLLS-1, so it can never wrap.
            if (poll_mode && busy_flag && (polls < POLL_LAST)) begin
              polls <= polls + 8'd1;
              state <= ST_GAP;
            end else begin
              done    <= 1'b1;
              timeout <= poll_mode & busy_flag;
              LCD_RW  <= 1'b0;
              state   <= ST_DONE;
            end
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            state <= ST_SETUP;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_rd = LCD_RW;

endmodule
